// File: rtl/core_interface_seq.sv
// Register-bank bridge between the instruction bus and one compute core, with a start/done
// handshake, run timeout and a continuous stream mode that re-triggers the core after every done.
module core_interface_seq #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 24,
   parameter int TOTAL_INPUTS  = 2,
   parameter int TOTAL_OUTPUTS = 1,
   parameter int START_ADDRESS = 0,
   parameter int RUN_TIMEOUT   = 1024
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                instr_valid_i,
   input  logic [7:0]                          instruction_i,
   input  logic [ADDR_WIDTH-1:0]               address_i,
   input  logic [DATA_WIDTH-1:0]               value_i,
   output logic [DATA_WIDTH-1:0]               result_o,
   output logic                                result_valid_o,
   output logic [DATA_WIDTH-1:0]               stream_o,
   output logic [TOTAL_INPUTS*DATA_WIDTH-1:0]  core_inputs_o,
   input  logic [TOTAL_OUTPUTS*DATA_WIDTH-1:0] core_outputs_i,
   output logic                                core_start_o,
   input  logic                                core_done_i,
   output logic                                busy_o,
   output logic                                error_o
);

   localparam int IN_W    = (TOTAL_INPUTS > 1) ? $clog2(TOTAL_INPUTS) : 1;
   localparam int OUT_W   = (TOTAL_OUTPUTS > 1) ? $clog2(TOTAL_OUTPUTS) : 1;
   localparam int TIMER_W = $clog2(RUN_TIMEOUT + 1);

   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(START_ADDRESS);
   localparam logic [TIMER_W-1:0]    TIMER_MAX = TIMER_W'(RUN_TIMEOUT);

   localparam logic [7:0] OP_WRITE   = 8'h01;
   localparam logic [7:0] OP_READ    = 8'h02;
   localparam logic [7:0] OP_RUN     = 8'h03;
   localparam logic [7:0] OP_STREAM  = 8'h04;
   localparam logic [7:0] OP_STOP    = 8'h05;
   localparam logic [7:0] OP_CLR_ERR = 8'h06;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT
   } state_t;

   state_t state, next_state;

   logic [DATA_WIDTH-1:0] in_regs  [TOTAL_INPUTS];
   logic [DATA_WIDTH-1:0] out_regs [TOTAL_OUTPUTS];
   logic [TIMER_W-1:0]    timer;
   logic [OUT_W-1:0]      sel;
   logic                  stream_on;

   logic [ADDR_WIDTH-1:0] idx;
   logic                  is_in, is_out;
   logic [IN_W-1:0]       in_idx;
   logic [OUT_W-1:0]      out_idx;
   logic [DATA_WIDTH-1:0] rd_data, sel_val;
   logic                  idle, wr_cmd, rd_cmd, run_cmd, stream_cmd, stop_cmd, clr_cmd;
   logic                  done_hit, timeout_hit, launch;

   // Addresses below START_ADDRESS wrap to huge offsets and so match nothing.
   assign idx = address_i - BASE;

   always_comb begin
      is_in   = 1'b0;
      is_out  = 1'b0;
      in_idx  = '0;
      out_idx = '0;
      for (int i = 0; i < TOTAL_INPUTS; i++) begin
         if (idx == ADDR_WIDTH'(i)) begin
            is_in  = 1'b1;
            in_idx = IN_W'(i);
         end
      end
      for (int i = 0; i < TOTAL_OUTPUTS; i++) begin
         if (idx == ADDR_WIDTH'(TOTAL_INPUTS + i)) begin
            is_out  = 1'b1;
            out_idx = OUT_W'(i);
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (is_in) begin
         rd_data = in_regs[in_idx];
      end else if (is_out) begin
         rd_data = out_regs[out_idx];
      end
   end

   always_comb begin
      sel_val = '0;
      for (int i = 0; i < TOTAL_OUTPUTS; i++) begin
         if (sel == OUT_W'(i)) begin
            sel_val = core_outputs_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign idle        = (state == S_IDLE);
   assign wr_cmd      = instr_valid_i && (instruction_i == OP_WRITE);
   assign rd_cmd      = instr_valid_i && (instruction_i == OP_READ) && (is_in || is_out);
   assign run_cmd     = instr_valid_i && (instruction_i == OP_RUN);
   assign stream_cmd  = instr_valid_i && (instruction_i == OP_STREAM) && is_out;
   assign stop_cmd    = instr_valid_i && (instruction_i == OP_STOP);
   assign clr_cmd     = instr_valid_i && (instruction_i == OP_CLR_ERR);
   assign done_hit    = (state == S_WAIT) && core_done_i;
   assign timeout_hit = (state == S_WAIT) && !core_done_i && (timer == TIMER_MAX);
   assign launch      = idle && (run_cmd || stream_cmd);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      core_start_o = 1'b0;
      busy_o       = 1'b1;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (launch) begin
               next_state = S_START;
            end
         end
         S_START: begin
            core_start_o = 1'b1;
            next_state   = S_WAIT;
         end
         S_WAIT: begin
            // A STOP arriving with done still lets this capture land, but blocks the re-trigger.
            if (done_hit) begin
               next_state = (stream_on && !stop_cmd) ? S_START : S_IDLE;
            end else if (timeout_hit) begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < TOTAL_INPUTS; i++) in_regs[i] <= '0;
         for (int i = 0; i < TOTAL_OUTPUTS; i++) out_regs[i] <= '0;
         timer          <= '0;
         sel            <= '0;
         stream_on      <= 1'b0;
         result_o       <= '0;
         result_valid_o <= 1'b0;
         stream_o       <= '0;
         error_o        <= 1'b0;
      end else begin
         result_valid_o <= rd_cmd;
         if (rd_cmd) begin
            result_o <= rd_data;
         end

         if (wr_cmd && is_in && idle) begin
            in_regs[in_idx] <= value_i;
         end

         if ((wr_cmd && !idle && (is_in || is_out)) || timeout_hit) begin
            error_o <= 1'b1;
         end else if (clr_cmd) begin
            error_o <= 1'b0;
         end

         if (state == S_START) begin
            timer <= TIMER_W'(1);
         end else if ((state == S_WAIT) && !done_hit && !timeout_hit) begin
            timer <= timer + TIMER_W'(1);
         end

         if (done_hit) begin
            for (int i = 0; i < TOTAL_OUTPUTS; i++) begin
               out_regs[i] <= core_outputs_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
            stream_o <= sel_val;
         end

         if (stream_cmd) begin
            sel <= out_idx;
         end

         if (timeout_hit || stop_cmd) begin
            stream_on <= 1'b0;
         end else if (stream_cmd && idle) begin
            stream_on <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < TOTAL_INPUTS; g++) begin : g_inputs
      assign core_inputs_o[g*DATA_WIDTH +: DATA_WIDTH] = in_regs[g];
   end

endmodule

// File: tb/tb_core_interface_seq.sv
// Directed bench for core_interface_seq: a table of idle-state register accesses plus
// hand-written run, stream, timeout, busy-write and reset sequences against an adder/xor core model.
module tb_core_interface_seq;

   localparam int DW = 32;
   localparam int AW = 24;

   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_WRITE   = 8'h01;
   localparam logic [7:0] OP_READ    = 8'h02;
   localparam logic [7:0] OP_RUN     = 8'h03;
   localparam logic [7:0] OP_STREAM  = 8'h04;
   localparam logic [7:0] OP_STOP    = 8'h05;
   localparam logic [7:0] OP_CLR_ERR = 8'h06;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          instr_valid = 1'b0;
   logic [7:0]    instruction = '0;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] value = '0;
   logic [DW-1:0] result;
   logic          result_valid;
   logic [DW-1:0] stream;
   logic [2*DW-1:0] core_inputs;
   logic [2*DW-1:0] core_outputs;
   logic          core_start;
   logic          core_done;
   logic          busy;
   logic          error;

   logic            model_done = 1'b0;
   logic [2*DW-1:0] model_out = '0;
   logic            man_done = 1'b0;
   logic [2*DW-1:0] man_out = '0;
   logic            core_auto = 1'b1;

   int total = 0;
   int bad = 0;
   int start_count = 0;

   assign core_done    = model_done | man_done;
   assign core_outputs = man_done ? man_out : model_out;

   always #5 clk = ~clk;

   core_interface_seq #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_INPUTS(2), .TOTAL_OUTPUTS(2),
      .START_ADDRESS('h10), .RUN_TIMEOUT(8)
   ) dut (
      .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instruction_i(instruction),
      .address_i(address), .value_i(value), .result_o(result), .result_valid_o(result_valid),
      .stream_o(stream), .core_inputs_o(core_inputs), .core_outputs_i(core_outputs),
      .core_start_o(core_start), .core_done_i(core_done), .busy_o(busy), .error_o(error)
   );

   // Core model: output0 = in0 + in1, output1 = in0 ^ in1, done two cycles after the start cycle.
   initial begin : core_model
      logic [DW-1:0] a, b;
      int pending;
      a = '0;
      b = '0;
      pending = 0;
      forever begin
         @(posedge clk);
         #2;
         model_done = 1'b0;
         if (rst) begin
            pending = 0;
         end else if (core_start && core_auto) begin
            a = core_inputs[DW-1:0];
            b = core_inputs[2*DW-1:DW];
            pending = 2;
         end else if (pending > 0) begin
            pending--;
            if (pending == 0) begin
               model_out  = {a ^ b, a + b};
               model_done = 1'b1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (core_start === 1'b1) start_count++;
   end

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] val);
      instr_valid = 1'b1;
      instruction = op;
      address     = addr;
      value       = val;
      @(negedge clk);
      instr_valid = 1'b0;
      instruction = OP_NOP;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_output(name, 64'(busy), 64'd0);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!core_done && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_output(name, 64'(core_done), 64'd1);
   endtask

   typedef struct {
      logic [7:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] val;
      logic          exp_valid;
      logic [DW-1:0] exp_result;
      logic [63:0]   exp_inputs;
      string         name;
   } vec_t;

   vec_t vecs[13];

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int s0, n;

      vecs[0]  = '{OP_WRITE, 24'h000010, 32'h0000_0005, 1'b0, 32'h0, 64'h0000_0000_0000_0005, "wr_in0"};
      vecs[1]  = '{OP_WRITE, 24'h000011, 32'h0000_0007, 1'b0, 32'h0, 64'h0000_0007_0000_0005, "wr_in1"};
      vecs[2]  = '{OP_READ,  24'h000010, 32'h0,         1'b1, 32'h5, 64'h0000_0007_0000_0005, "rd_in0"};
      vecs[3]  = '{OP_READ,  24'h000011, 32'h0,         1'b1, 32'h7, 64'h0000_0007_0000_0005, "rd_in1"};
      vecs[4]  = '{OP_WRITE, 24'h00000F, 32'hDEAD_0000, 1'b0, 32'h0, 64'h0000_0007_0000_0005, "wr_below"};
      vecs[5]  = '{OP_WRITE, 24'h000014, 32'hBEEF_0000, 1'b0, 32'h0, 64'h0000_0007_0000_0005, "wr_above"};
      vecs[6]  = '{OP_WRITE, 24'h000013, 32'h0000_1234, 1'b0, 32'h0, 64'h0000_0007_0000_0005, "wr_outreg"};
      vecs[7]  = '{OP_READ,  24'h00000F, 32'h0,         1'b0, 32'h0, 64'h0000_0007_0000_0005, "rd_below"};
      vecs[8]  = '{OP_READ,  24'h000014, 32'h0,         1'b0, 32'h0, 64'h0000_0007_0000_0005, "rd_above"};
      vecs[9]  = '{OP_READ,  24'h000012, 32'h0,         1'b1, 32'h0, 64'h0000_0007_0000_0005, "rd_out0"};
      vecs[10] = '{OP_NOP,   24'h000010, 32'h0000_0099, 1'b0, 32'h0, 64'h0000_0007_0000_0005, "nop"};
      vecs[11] = '{8'h7F,    24'h000011, 32'h0000_0001, 1'b0, 32'h0, 64'h0000_0007_0000_0005, "bad_op"};
      vecs[12] = '{OP_READ,  24'hFFFFFF, 32'h0,         1'b0, 32'h0, 64'h0000_0007_0000_0005, "rd_wrap"};

      repeat (3) @(negedge clk);
      check_output("rst_result", 64'(result), 64'd0);
      check_output("rst_flags", {60'd0, result_valid, core_start, busy, error}, 64'd0);
      check_output("rst_stream", 64'(stream), 64'd0);
      check_output("rst_inputs", core_inputs, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] idle register table");
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].op, vecs[i].addr, vecs[i].val);
         check_output({vecs[i].name, "_valid"}, 64'(result_valid), 64'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) check_output({vecs[i].name, "_result"}, 64'(result), 64'(vecs[i].exp_result));
         check_output({vecs[i].name, "_inputs"}, core_inputs, vecs[i].exp_inputs);
         check_output({vecs[i].name, "_busy"}, 64'(busy), 64'd0);
         check_output({vecs[i].name, "_error"}, 64'(error), 64'd0);
      end
      @(negedge clk);
      check_output("valid_one_pulse", 64'(result_valid), 64'd0);

      $display("[TB] single run");
      s0 = start_count;
      apply_stimulus(OP_RUN, 24'h000055, 32'h0);
      check_output("run_start", {62'd0, core_start, busy}, 64'd3);
      wait_idle("run_finish");
      check_output("run_starts", 64'(start_count - s0), 64'd1);
      apply_stimulus(OP_READ, 24'h000012, 32'h0);
      check_output("run_sum", {31'd0, result_valid, result}, {31'd0, 1'b1, 32'h0000_000C});
      @(negedge clk);
      check_output("run_sum_pulse", 64'(result_valid), 64'd0);
      apply_stimulus(OP_READ, 24'h000013, 32'h0);
      check_output("run_xor", 64'(result), 64'h2);
      check_output("run_stream_sel0", 64'(stream), 64'hC);

      $display("[TB] stream on output 0");
      apply_stimulus(OP_WRITE, 24'h000010, 32'h0000_0021);
      s0 = start_count;
      apply_stimulus(OP_STREAM, 24'h000012, 32'h0);
      check_output("strA_start", 64'(core_start), 64'd1);
      wait_done("strA_done1");
      @(negedge clk);
      check_output("strA_retrig1", 64'(core_start), 64'd1);
      check_output("strA_stream", 64'(stream), 64'h28);
      wait_done("strA_done2");
      @(negedge clk);
      check_output("strA_retrig2", 64'(core_start), 64'd1);
      apply_stimulus(OP_STOP, 24'h0, 32'h0);
      wait_idle("strA_stop_idle");
      repeat (4) @(negedge clk);
      check_output("strA_starts", 64'(start_count - s0), 64'd3);
      check_output("strA_stay_idle", {62'd0, busy, core_start}, 64'd0);
      check_output("strA_stream_end", 64'(stream), 64'h28);

      $display("[TB] stream on output 1 with same-cycle read and stop");
      apply_stimulus(OP_WRITE, 24'h000010, 32'h0000_0105);
      s0 = start_count;
      apply_stimulus(OP_STREAM, 24'h000013, 32'h0);
      wait_done("strB_done1");
      apply_stimulus(OP_READ, 24'h000012, 32'h0);
      check_output("strB_precapture", {31'd0, result_valid, result}, {31'd0, 1'b1, 32'h28});
      check_output("strB_stream", 64'(stream), 64'h102);
      check_output("strB_retrig", 64'(core_start), 64'd1);
      wait_done("strB_done2");
      apply_stimulus(OP_STOP, 24'h0, 32'h0);
      check_output("strB_stop_done", {62'd0, busy, core_start}, 64'd0);
      check_output("strB_starts", 64'(start_count - s0), 64'd2);
      apply_stimulus(OP_READ, 24'h000012, 32'h0);
      check_output("strB_sum", 64'(result), 64'h10C);

      $display("[TB] timeout");
      core_auto = 1'b0;
      apply_stimulus(OP_RUN, 24'h0, 32'h0);
      n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      check_output("to_wait_cycles", 64'(n), 64'd8);
      check_output("to_error", {62'd0, busy, error}, 64'd1);
      apply_stimulus(OP_READ, 24'h000012, 32'h0);
      check_output("to_out_kept", 64'(result), 64'h10C);
      apply_stimulus(OP_CLR_ERR, 24'h0, 32'h0);
      check_output("to_clr_err", 64'(error), 64'd0);

      $display("[TB] write and run while busy");
      core_auto = 1'b1;
      s0 = start_count;
      apply_stimulus(OP_RUN, 24'h0, 32'h0);
      @(negedge clk);
      apply_stimulus(OP_WRITE, 24'h000010, 32'h0000_FFFF);
      check_output("busy_wr_inputs", core_inputs, 64'h0000_0007_0000_0105);
      check_output("busy_wr_error", 64'(error), 64'd1);
      apply_stimulus(OP_RUN, 24'h0, 32'h0);
      wait_idle("busy_run_idle");
      repeat (3) @(negedge clk);
      check_output("busy_run_starts", 64'(start_count - s0), 64'd1);
      apply_stimulus(OP_CLR_ERR, 24'h0, 32'h0);
      check_output("busy_clr_err", 64'(error), 64'd0);

      $display("[TB] reset mid-run");
      core_auto = 1'b0;
      apply_stimulus(OP_RUN, 24'h0, 32'h0);
      apply_stimulus(OP_WRITE, 24'h000011, 32'h0000_0055);
      check_output("rr_error_set", {62'd0, busy, error}, 64'd3);
      #2 rst = 1'b1;
      #1;
      check_output("rr_flags", {60'd0, result_valid, core_start, busy, error}, 64'd0);
      check_output("rr_inputs", core_inputs, 64'd0);
      check_output("rr_result_stream", {result, stream}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      s0 = start_count;
      man_out  = 64'h0000_ABCD_0000_1234;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      @(negedge clk);
      check_output("rr_late_done", {62'd0, busy, core_start}, 64'd0);
      check_output("rr_no_start", 64'(start_count - s0), 64'd0);
      check_output("rr_stream_kept", 64'(stream), 64'd0);
      apply_stimulus(OP_READ, 24'h000012, 32'h0);
      check_output("rr_out_cleared", {31'd0, result_valid, result}, {31'd0, 1'b1, 32'h0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
